// File: rtl/sa_col_feeder.sv
// Read-side feeder from the ping-pong buffer to the systolic array columns.
// Pulls one tile of words, skews lane i by i cycles, and pulses done once drained.

module sa_skew_lane #(
  parameter int W     = 16,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         vld_i,
  input  logic [W-1:0] din_i,
  output logic         vld_o,
  output logic [W-1:0] dout_o
);
  logic [DEPTH-1:0]        vld_pipe_q;
  logic [DEPTH-1:0][W-1:0] dat_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      dat_q      <= '0;
    end else begin
      vld_pipe_q[0] <= vld_i;
      // zero is loaded on idle cycles so invalid lanes always read as 0
      dat_q[0]      <= vld_i ? din_i : '0;
      for (int k = 1; k < DEPTH; k++) begin
        vld_pipe_q[k] <= vld_pipe_q[k-1];
        dat_q[k]      <= dat_q[k-1];
      end
    end
  end

  assign vld_o  = vld_pipe_q[DEPTH-1];
  assign dout_o = dat_q[DEPTH-1];
endmodule

module sa_col_feeder #(
  parameter int LANES    = 8,
  parameter int LANE_W   = 16,
  parameter int DATA_W   = LANES * LANE_W,
  parameter int TILE_LEN = 512,
  parameter int CNT_W    = $clog2(TILE_LEN) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              buf_rrdy,
  input  logic              buf_empty,
  output logic              buf_rd_en,
  input  logic [DATA_W-1:0] buf_dout,
  output logic [DATA_W-1:0] col_data,
  output logic [LANES-1:0]  col_valid,
  output logic              busy,
  output logic              done
);
  localparam int DW = $clog2(LANES + 1);

  typedef enum logic [1:0] {IDLE, WAIT, FETCH, DRAIN} state_t;

  state_t           state_q;
  logic [CNT_W-1:0] rcnt_q, rcnt_d;
  logic [DW-1:0]    dcnt_q;
  logic             done_q;
  logic             rvld_q;

  assign buf_rd_en = (state_q == FETCH) && !buf_empty && (rcnt_q < CNT_W'(TILE_LEN));
  assign rcnt_d    = rcnt_q + CNT_W'(buf_rd_en);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      dcnt_q  <= '0;
      done_q  <= 1'b0;
      rvld_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      rvld_q <= buf_rd_en;
      case (state_q)
        IDLE: if (start) begin
          state_q <= WAIT;
          rcnt_q  <= '0;
        end
        WAIT: if (buf_rrdy) state_q <= FETCH;
        FETCH: begin
          rcnt_q <= rcnt_d;
          if (rcnt_d == CNT_W'(TILE_LEN)) begin
            state_q <= DRAIN;
            dcnt_q  <= '0;
          end
        end
        DRAIN: begin
          // LANES+1 drain cycles cover the deepest lane; done lands on the last one
          dcnt_q <= dcnt_q + 1'b1;
          if (dcnt_q == DW'(LANES - 1)) done_q <= 1'b1;
          if (dcnt_q == DW'(LANES)) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    sa_skew_lane #(.W(LANE_W), .DEPTH(i + 1)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .vld_i  (rvld_q),
      .din_i  (buf_dout[i*LANE_W +: LANE_W]),
      .vld_o  (col_valid[i]),
      .dout_o (col_data[i*LANE_W +: LANE_W])
    );
  end
endmodule

// File: tb/tb_sa_col_feeder.sv
// Bench for sa_col_feeder: a 4-word-tile instance for directed/random work and a
// default 512-word instance for back-to-back tiles, both checked every cycle by a timing model.

module tb_sa_col_feeder;
  localparam int LANES = 8, LANE_W = 16, DATA_W = 128, TL0 = 4, TL1 = 512, HN = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic [1:0] start_v, rrdy_v, empty_v, rd_v, busy_v, done_v;
  logic [1:0][DATA_W-1:0] dout_v, cd_v;
  logic [1:0][LANES-1:0] cv_v;

  sa_col_feeder #(.LANES(LANES), .LANE_W(LANE_W), .TILE_LEN(TL0)) u_small (
    .clk(clk), .rst(rst), .start(start_v[0]), .buf_rrdy(rrdy_v[0]), .buf_empty(empty_v[0]),
    .buf_rd_en(rd_v[0]), .buf_dout(dout_v[0]), .col_data(cd_v[0]), .col_valid(cv_v[0]),
    .busy(busy_v[0]), .done(done_v[0]));

  sa_col_feeder u_big (
    .clk(clk), .rst(rst), .start(start_v[1]), .buf_rrdy(rrdy_v[1]), .buf_empty(empty_v[1]),
    .buf_rd_en(rd_v[1]), .buf_dout(dout_v[1]), .col_data(cd_v[1]), .col_valid(cv_v[1]),
    .busy(busy_v[1]), .done(done_v[1]));

  typedef struct {
    logic st, rdy, emp;
    logic rd, busy, done;
    logic [LANES-1:0] cv;
  } vec_t;

  int n_cmp, n_err, cyc, last_rst;
  logic m_busy[2], m_wait[2], m_fetch[2], pend[2];
  int reads[2], last_rd[2], obs_rd[2], obs_done[2];
  logic [DATA_W-1:0] pend_w[2];
  logic [DATA_W-1:0] tw[2][TL1];
  logic hv[2][HN];
  logic [DATA_W-1:0] hw[2][HN];
  logic o_rd, o_busy, o_done;
  logic [LANES-1:0] o_cv;
  vec_t tbl[16];

  task automatic chk(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, want %h", nm, cyc, act, exp);
    end
  endtask

  task automatic fill(input int d, input bit rnd);
    for (int k = 0; k < TL1; k++)
      for (int i = 0; i < LANES; i++)
        tw[d][k][i*LANE_W +: LANE_W] = rnd ? 16'($urandom()) : {k[11:0], i[3:0]};
  endtask

  // One clock cycle on instance d: drive, sample, compare against the model, advance.
  task automatic step(input int d, input logic st, input logic rdy, input logic emp, input logic r);
    logic exp_rd, exp_done;
    logic [LANES-1:0] ev;
    logic [DATA_W-1:0] ed;
    int src, tl;
    tl = (d == 0) ? TL0 : TL1;
    rst = r;
    start_v = '0; rrdy_v = '0; empty_v = 2'b11; dout_v = '0;
    start_v[d] = st; rrdy_v[d] = rdy; empty_v[d] = emp;
    dout_v[d] = pend[d] ? pend_w[d] : {$urandom(), $urandom(), $urandom(), $urandom()};
    #1;
    exp_rd   = m_fetch[d] && !emp && (reads[d] < tl);
    exp_done = m_busy[d] && (reads[d] == tl) && (cyc == last_rd[d] + LANES + 1);
    ev = '0; ed = '0;
    for (int i = 0; i < LANES; i++) begin
      src = cyc - 2 - i;
      if (src >= 0 && src > last_rst && hv[d][src % HN]) begin
        ev[i] = 1'b1;
        ed[i*LANE_W +: LANE_W] = hw[d][src % HN][i*LANE_W +: LANE_W];
      end
    end
    o_rd = rd_v[d]; o_busy = busy_v[d]; o_done = done_v[d]; o_cv = cv_v[d];
    chk("rd_en", DATA_W'(rd_v[d]), DATA_W'(exp_rd));
    chk("busy", DATA_W'(busy_v[d]), DATA_W'(m_busy[d]));
    chk("done", DATA_W'(done_v[d]), DATA_W'(exp_done));
    chk("col_valid", DATA_W'(cv_v[d]), DATA_W'(ev));
    chk("col_data", cd_v[d], ed);
    if (rd_v[d]) obs_rd[d]++;
    if (done_v[d]) obs_done[d]++;
    hv[d][cyc % HN] = exp_rd && !r;
    hw[d][cyc % HN] = exp_rd ? tw[d][reads[d]] : '0;
    hv[1-d][cyc % HN] = 1'b0;
    if (r) begin
      for (int j = 0; j < 2; j++) begin
        m_busy[j] = 0; m_wait[j] = 0; m_fetch[j] = 0; pend[j] = 0;
      end
      last_rst = cyc;
    end else begin
      if (exp_done) m_busy[d] = 1'b0;
      else if (!m_busy[d] && st) begin
        m_busy[d] = 1'b1; m_wait[d] = 1'b1; reads[d] = 0;
      end else if (m_wait[d] && rdy) begin
        m_wait[d] = 1'b0; m_fetch[d] = 1'b1;
      end
      if (exp_rd) begin
        pend_w[d] = tw[d][reads[d]];
        reads[d]++;
        last_rd[d] = cyc;
        if (reads[d] == tl) m_fetch[d] = 1'b0;
      end
      pend[d] = exp_rd;
    end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic setv(input int i, input logic st, input logic rd, input logic bz,
                      input logic dn, input logic [LANES-1:0] cv);
    tbl[i] = '{st: st, rdy: 1'b1, emp: 1'b0, rd: rd, busy: bz, done: dn, cv: cv};
  endtask

  task automatic chk_idle(input string nm);
    chk({nm, "_valid"}, DATA_W'(o_cv), '0);
    chk({nm, "_busy"}, DATA_W'(o_busy), '0);
    chk({nm, "_done"}, DATA_W'(o_done), '0);
    chk({nm, "_rd"}, DATA_W'(o_rd), '0);
  endtask

  initial begin
    int rd0, dn0, started, k;
    logic st;
    n_cmp = 0; n_err = 0; cyc = 0; last_rst = -1;
    for (int j = 0; j < 2; j++) begin
      m_busy[j] = 0; m_wait[j] = 0; m_fetch[j] = 0; pend[j] = 0;
      reads[j] = 0; last_rd[j] = 0; obs_rd[j] = 0; obs_done[j] = 0; pend_w[j] = '0;
      for (int h = 0; h < HN; h++) begin hv[j][h] = 0; hw[j][h] = '0; end
    end
    fill(0, 0); fill(1, 0);

    // expected cycle-by-cycle trace for one 4-word tile with the buffer always full
    setv(0, 1, 0, 0, 0, 8'h00); setv(1, 0, 0, 1, 0, 8'h00);
    setv(2, 0, 1, 1, 0, 8'h00); setv(3, 0, 1, 1, 0, 8'h00);
    setv(4, 0, 1, 1, 0, 8'h01); setv(5, 0, 1, 1, 0, 8'h03);
    setv(6, 0, 0, 1, 0, 8'h07); setv(7, 0, 0, 1, 0, 8'h0F);
    setv(8, 0, 0, 1, 0, 8'h1E); setv(9, 0, 0, 1, 0, 8'h3C);
    setv(10, 0, 0, 1, 0, 8'h78); setv(11, 0, 0, 1, 0, 8'hF0);
    setv(12, 0, 0, 1, 0, 8'hE0); setv(13, 0, 0, 1, 0, 8'hC0);
    setv(14, 0, 0, 1, 1, 8'h80); setv(15, 0, 0, 0, 0, 8'h00);

    rst = 1'b1; start_v = '0; rrdy_v = '0; empty_v = '0; dout_v = '0;
    @(posedge clk); #1;
    step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk_idle("reset");

    // reset held two cycles in the middle of a drain
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1); step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
    chk_idle("rst_drain");
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0);

    dn0 = obs_done[0]; rd0 = obs_rd[0];
    for (int i = 0; i < 16; i++) begin
      step(0, tbl[i].st, tbl[i].rdy, tbl[i].emp, 1'b0);
      chk($sformatf("tbl%0d_rd", i), DATA_W'(o_rd), DATA_W'(tbl[i].rd));
      chk($sformatf("tbl%0d_busy", i), DATA_W'(o_busy), DATA_W'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i), DATA_W'(o_done), DATA_W'(tbl[i].done));
      chk($sformatf("tbl%0d_cv", i), DATA_W'(o_cv), DATA_W'(tbl[i].cv));
    end
    chk("tbl_reads", obs_rd[0] - rd0, 4);
    chk("tbl_dones", obs_done[0] - dn0, 1);

    // buffer empty for 3 cycles after word 1
    dn0 = obs_done[0]; rd0 = obs_rd[0];
    step(0, 1, 1, 0, 0); step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0); step(0, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 0);
      chk("gap_rd", DATA_W'(o_rd), '0);
    end
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0);
    chk("gap_reads", obs_rd[0] - rd0, 4);
    chk("gap_dones", obs_done[0] - dn0, 1);

    // start pulses mid-FETCH and mid-DRAIN are ignored
    dn0 = obs_done[0]; rd0 = obs_rd[0];
    step(0, 1, 1, 0, 0); step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0); step(0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
    step(0, 1, 1, 0, 0);
    for (int i = 0; i < 16; i++) step(0, 0, 1, 0, 0);
    chk("restart_reads", obs_rd[0] - rd0, 4);
    chk("restart_dones", obs_done[0] - dn0, 1);

    // reset in the second FETCH cycle discards the tile
    dn0 = obs_done[0];
    step(0, 1, 1, 0, 0); step(0, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0); step(0, 0, 1, 0, 1);
    step(0, 0, 1, 0, 0);
    chk_idle("rst_fetch");
    for (int i = 0; i < 20; i++) step(0, 0, 1, 0, 0);
    chk("rst_fetch_dones", obs_done[0] - dn0, 0);

    // random start spam, rrdy, empty and rare resets
    fill(0, 1);
    for (int i = 0; i < 1500; i++)
      step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 2) == 0, $urandom_range(0, 149) == 0);
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) step(0, 0, 0, 0, 0);

    // default-size instance: two back-to-back tiles, restart in the cycle after done
    dn0 = obs_done[1]; rd0 = obs_rd[1];
    started = 1; st = 1'b1; k = 0;
    while (k < 4000 && obs_done[1] - dn0 < 2) begin
      step(1, st, 1'b1, $urandom_range(0, 7) == 0, 1'b0);
      st = o_done && (started < 2);
      if (st) started++;
      k++;
    end
    for (int i = 0; i < 12; i++) step(1, 0, 1, 0, 0);
    chk("big_reads", obs_rd[1] - rd0, 2 * TL1);
    chk("big_dones", obs_done[1] - dn0, 2);
    chk("big_idle", DATA_W'(o_busy), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
